// File: rtl/multicycle_stage_ctrl.sv
// Multicycle MIPS stage-sequencing controller.
// Steps each instruction through F/D/E/M/W, skipping the stages its opcode class
// does not need. It handles imem/dmem req/ack stalls, a global freeze, an optional
// stall watchdog, an absorbing TRAP state and a retired-instruction counter.
module multicycle_stage_ctrl #(
  parameter int OP_W      = 6,
  parameter int FUNC_W    = 6,
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic [2:0]        state,
  output logic              rf_we,
  output logic              instr_retire,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              trap,
  output logic [1:0]        trap_cause
);

  localparam logic [2:0] S_F    = 3'd1;
  localparam logic [2:0] S_D    = 3'd2;
  localparam logic [2:0] S_E    = 3'd3;
  localparam logic [2:0] S_M    = 3'd4;
  localparam logic [2:0] S_W    = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd6;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_R    = 3'd1;
  localparam logic [2:0] C_ADDI = 3'd2;
  localparam logic [2:0] C_J    = 3'd3;
  localparam logic [2:0] C_BEQ  = 3'd4;
  localparam logic [2:0] C_LW   = 3'd5;
  localparam logic [2:0] C_SW   = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_IMEM = 2'd2;
  localparam logic [1:0] CAUSE_DMEM = 2'd3;

  // Watchdog counts 0..STALL_MAX-1; the last unacked cycle traps.
  localparam int              WD_W    = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((STALL_MAX > 0) ? (STALL_MAX - 1) : 0);
  localparam bit              WD_ON   = (STALL_MAX > 0);

  logic [2:0]       r_state;
  logic [2:0]       r_cls;
  logic [WD_W-1:0]  r_wd;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_trap_cause;

  logic [2:0]       w_dec_cls;
  logic [2:0]       w_next_state;
  logic [WD_W-1:0]  w_wd_next;
  logic [1:0]       w_cause_next;
  logic             w_retire;
  logic             w_fetch_done;

  // Classify the incoming opcode/func pair.
  always_comb begin
    w_dec_cls = C_ILL;
    if (op == '0) begin
      w_dec_cls = (func == '0) ? C_NOP : C_R;
    end else if (op == OP_W'(8'h08)) begin
      w_dec_cls = C_ADDI;
    end else if (op == OP_W'(8'h02)) begin
      w_dec_cls = C_J;
    end else if (op == OP_W'(8'h04)) begin
      w_dec_cls = C_BEQ;
    end else if (op == OP_W'(8'h23)) begin
      w_dec_cls = C_LW;
    end else if (op == OP_W'(8'h2B)) begin
      w_dec_cls = C_SW;
    end
  end

  assign w_fetch_done = (r_state == S_F) && imem_ack && !freeze;

  // Next state, retire, watchdog and trap cause; freeze holds everything.
  always_comb begin
    w_next_state = r_state;
    w_wd_next    = r_wd;
    w_cause_next = r_trap_cause;
    w_retire     = 1'b0;
    if (!freeze) begin
      case (r_state)
        S_F: begin
          if (imem_ack) begin
            w_next_state = S_D;
            w_wd_next    = '0;
          end else if (WD_ON) begin
            if (r_wd == WD_LAST) begin
              w_next_state = S_TRAP;
              w_cause_next = CAUSE_IMEM;
              w_wd_next    = '0;
            end else begin
              w_wd_next = r_wd + WD_W'(1);
            end
          end
        end
        S_D: begin
          w_wd_next = '0;
          case (r_cls)
            C_NOP, C_J: begin
              w_next_state = S_F;
              w_retire     = 1'b1;
            end
            C_ILL: begin
              w_next_state = S_TRAP;
              w_cause_next = CAUSE_ILL;
            end
            default: w_next_state = S_E;
          endcase
        end
        S_E: begin
          w_wd_next = '0;
          case (r_cls)
            C_BEQ: begin
              w_next_state = S_F;
              w_retire     = 1'b1;
            end
            C_LW, C_SW: w_next_state = S_M;
            default:    w_next_state = S_W;
          endcase
        end
        S_M: begin
          if (dmem_ack) begin
            w_wd_next = '0;
            if (r_cls == C_SW) begin
              w_next_state = S_F;
              w_retire     = 1'b1;
            end else begin
              w_next_state = S_W;
            end
          end else if (WD_ON) begin
            if (r_wd == WD_LAST) begin
              w_next_state = S_TRAP;
              w_cause_next = CAUSE_DMEM;
              w_wd_next    = '0;
            end else begin
              w_wd_next = r_wd + WD_W'(1);
            end
          end
        end
        S_W: begin
          w_wd_next    = '0;
          w_next_state = S_F;
          w_retire     = 1'b1;
        end
        S_TRAP: begin
          w_wd_next = '0;
        end
        default: begin
          w_next_state = S_F;
          w_wd_next    = '0;
        end
      endcase
    end
  end

  // State, class, watchdog, retire counter and trap cause registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_F;
      r_cls        <= C_NOP;
      r_wd         <= '0;
      r_cnt        <= '0;
      r_trap_cause <= '0;
    end else begin
      r_state      <= w_next_state;
      r_wd         <= w_wd_next;
      r_trap_cause <= w_cause_next;
      if (w_fetch_done) begin
        r_cls <= w_dec_cls;
      end
      if (w_retire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign state        = r_state;
  assign imem_req     = !reset && (r_state == S_F);
  assign dmem_req     = !reset && (r_state == S_M);
  assign dmem_we      = !reset && (r_state == S_M) && (r_cls == C_SW);
  assign rf_we        = !reset && (r_state == S_W);
  assign instr_retire = !reset && w_retire;
  assign retire_cnt   = r_cnt;
  assign trap         = !reset && (r_state == S_TRAP);
  assign trap_cause   = r_trap_cause;

endmodule

// File: tb/tb_multicycle_stage_ctrl.sv
// Scoreboard bench for multicycle_stage_ctrl (CNT_W=4, STALL_MAX=4).
// Each queued entry carries the inputs for one cycle and the expected outputs.
module tb_multicycle_stage_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       freeze = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, rf_we, instr_retire, trap;
  logic [2:0] state;
  logic [3:0] retire_cnt;
  logic [1:0] trap_cause;

  multicycle_stage_ctrl #(
    .OP_W(6), .FUNC_W(6), .CNT_W(4), .STALL_MAX(4)
  ) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .op(op), .func(func),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .state(state), .rf_we(rf_we),
    .instr_retire(instr_retire), .retire_cnt(retire_cnt), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iack;
    logic       dack;
    logic       frz;
    logic [5:0] op;
    logic [5:0] func;
    logic [8:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {state, imem_req, dmem_req, dmem_we, rf_we, instr_retire, trap}
  function automatic logic [8:0] mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                    input logic dwe, input logic rfwe, input logic ret,
                                    input logic trp);
    return {st, ireq, dreq, dwe, rfwe, ret, trp};
  endfunction

  function automatic logic [8:0] obs();
    return {state, imem_req, dmem_req, dmem_we, rf_we, instr_retire, trap};
  endfunction

  function automatic void push(input logic iack, input logic dack, input logic frz,
                               input logic [5:0] o, input logic [5:0] f, input logic [8:0] e);
    cyc_t c;
    c.iack = iack; c.dack = dack; c.frz = frz; c.op = o; c.func = f; c.exp = e;
    q.push_back(c);
  endfunction

  // Expected per-cycle trace of one instruction, derived from its opcode class.
  function automatic void push_instr(input logic [5:0] o, input logic [5:0] f,
                                     input int iwait, input int dwait);
    bit has_e = 0, has_m = 0, has_w = 0, ill = 0, is_sw = 0;
    if (o == 6'h00) begin
      has_e = (f != 0); has_w = (f != 0);
    end else begin
      case (o)
        6'h08: begin has_e = 1; has_w = 1; end
        6'h02: ;
        6'h04: has_e = 1;
        6'h23: begin has_e = 1; has_m = 1; has_w = 1; end
        6'h2B: begin has_e = 1; has_m = 1; is_sw = 1; end
        default: ill = 1;
      endcase
    end
    for (int i = 0; i <= iwait; i++)
      push(i == iwait, 1'b0, 1'b0, o, f, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, o, f, mk(3'd2, 0, 0, 0, 0, !ill && !has_e, 0));
    if (!ill) begin
      if (has_e) push(1'b0, 1'b0, 1'b0, o, f, mk(3'd3, 0, 0, 0, 0, !has_m && !has_w, 0));
      if (has_m)
        for (int j = 0; j <= dwait; j++)
          push(1'b0, j == dwait, 1'b0, o, f, mk(3'd4, 0, 1, is_sw, 0, (j == dwait) && !has_w, 0));
      if (has_w) push(1'b0, 1'b0, 1'b0, o, f, mk(3'd5, 0, 0, 0, 1, 1, 0));
      m_cnt = (m_cnt + 1) % 16;
    end
  endfunction

  task automatic run_q(input string tag);
    cyc_t c;
    int   k = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      imem_ack = c.iack; dmem_ack = c.dack; freeze = c.frz; op = c.op; func = c.func;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, k), 32'(obs()), 32'(c.exp));
      k++;
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; freeze = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; freeze = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ireq", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    // 1: reset state, then ADDI with immediate fetch ack
    do_reset();
    check("rst_state", 32'(state), 32'd1);
    check("rst_cnt", 32'(retire_cnt), 32'd0);
    check("rst_trap", {30'd0, trap_cause}, 32'd0);
    push_instr(6'h08, 6'h00, 0, 0);
    run_q("addi");
    check("addi_cnt", 32'(retire_cnt), 32'(m_cnt));
    check("addi_end_state", 32'(state), 32'd1);

    // R-type with freeze: freeze+ack in F ignored, freeze holds D and W
    push(1'b1, 1'b0, 1'b1, 6'h00, 6'h20, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, 1'b0, 6'h00, 6'h20, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b1, 6'h00, 6'h20, mk(3'd2, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, mk(3'd2, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, mk(3'd3, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b1, 6'h00, 6'h20, mk(3'd5, 0, 0, 0, 1, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, mk(3'd5, 0, 0, 0, 1, 1, 0));
    m_cnt = (m_cnt + 1) % 16;
    run_q("rfrz");
    check("rfrz_cnt", 32'(retire_cnt), 32'(m_cnt));

    // 2: LW with dmem ack delayed 3 cycles
    push_instr(6'h23, 6'h00, 0, 3);
    run_q("lw");
    check("lw_cnt", 32'(retire_cnt), 32'(m_cnt));

    // 3: SW, J, NOP back-to-back
    do_reset();
    push_instr(6'h2B, 6'h00, 0, 2);
    push_instr(6'h02, 6'h00, 1, 0);
    push_instr(6'h00, 6'h00, 0, 0);
    run_q("sw_j_nop");
    check("sjn_cnt", 32'(retire_cnt), 32'd3);

    // 4: illegal opcode -> TRAP; freeze and acks have no effect there
    push_instr(6'h3F, 6'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      push(i[0], i[1], i[2], 6'h00, 6'h00, mk(3'd6, 0, 0, 0, 0, 0, 1));
    run_q("ill");
    check("ill_cause", {30'd0, trap_cause}, 32'd1);
    check("ill_cnt", 32'(retire_cnt), 32'd3);

    // 5: fetch watchdog with two frozen cycles during the wait
    do_reset();
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b1, 6'h00, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b1, 6'h00, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      push(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, mk(3'd6, 0, 0, 0, 0, 0, 1));
    run_q("wd_imem");
    check("wdi_cause", {30'd0, trap_cause}, 32'd2);

    // data-side watchdog: LW whose dmem ack never arrives
    do_reset();
    push(1'b1, 1'b0, 1'b0, 6'h23, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, mk(3'd2, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, mk(3'd3, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, mk(3'd4, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, mk(3'd6, 0, 0, 0, 0, 0, 1));
    run_q("wd_dmem");
    check("wdd_cause", {30'd0, trap_cause}, 32'd3);
    check("wdd_cnt", 32'(retire_cnt), 32'd0);

    // 6: counter wrap at 16, then async reset in E of BEQ
    do_reset();
    for (int i = 0; i < 15; i++) push_instr(6'h00, 6'h00, 0, 0);
    run_q("nop15");
    check("cnt15", 32'(retire_cnt), 32'd15);
    push_instr(6'h00, 6'h00, 0, 0);
    run_q("nop16");
    check("cnt_wrap", 32'(retire_cnt), 32'd0);
    push_instr(6'h00, 6'h00, 0, 0);
    run_q("nop17");
    check("cnt_after_wrap", 32'(retire_cnt), 32'd1);
    push(1'b1, 1'b0, 1'b0, 6'h04, 6'h00, mk(3'd1, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 6'h04, 6'h00, mk(3'd2, 0, 0, 0, 0, 0, 0));
    run_q("beq");
    @(negedge clk);
    check("beq_in_e", 32'(state), 32'd3);
    check("beq_e_retire", 32'(instr_retire), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd1);
    check("arst_retire", 32'(instr_retire), 32'd0);
    check("arst_cnt", 32'(retire_cnt), 32'd0);
    check("arst_ireq", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0;
    push_instr(6'h00, 6'h00, 0, 0);
    run_q("post_rst_nop");
    check("post_rst_cnt", 32'(retire_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
